// File: rtl/scan_line_trigger_if.sv
// Signal bundle between the encoder front-end / host registers and the
// line-trigger scheduler. The slave modport is the scheduler's view.
interface scan_line_trigger_if #(
    parameter int POS_W  = 32,
    parameter int DIV_W  = 16,
    parameter int LINE_W = 16
);
    logic              ENC_FWD;
    logic              ENC_REV;
    logic [DIV_W-1:0]  CFG_DIV;
    logic [LINE_W-1:0] CFG_LINES;
    logic              START;
    logic              ABORT;
    logic              ACQ_BUSY;
    logic              LINE_TRIG;
    logic [LINE_W-1:0] LINE_NUM;
    logic [POS_W-1:0]  POSITION;
    logic              SCAN_ACTIVE;
    logic              SCAN_DONE;
    logic              OVERRUN;
    logic [LINE_W-1:0] MISSED_CNT;

    modport master (
        output ENC_FWD, ENC_REV, CFG_DIV, CFG_LINES, START, ABORT, ACQ_BUSY,
        input  LINE_TRIG, LINE_NUM, POSITION, SCAN_ACTIVE, SCAN_DONE,
               OVERRUN, MISSED_CNT
    );

    modport slave (
        input  ENC_FWD, ENC_REV, CFG_DIV, CFG_LINES, START, ABORT, ACQ_BUSY,
        output LINE_TRIG, LINE_NUM, POSITION, SCAN_ACTIVE, SCAN_DONE,
               OVERRUN, MISSED_CNT
    );
endinterface

// File: rtl/scan_line_trigger.sv
// Line-trigger scheduler: tracks absolute encoder position and, during a
// scan, divides forward motion into line triggers for the acquisition path.
module scan_line_trigger #(
    parameter int POS_W  = 32,
    parameter int DIV_W  = 16,
    parameter int LINE_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    scan_line_trigger_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic [DIV_W:0] ACC_MIN = {1'b1, {DIV_W{1'b0}}};

    state_e            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DIV_W:0]    acc_q, acc_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LINE_W-1:0] lines_q, lines_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic              line_trig_q, line_trig_d;
    logic [LINE_W-1:0] line_num_q, line_num_d;
    logic              scan_active_q, scan_active_d;
    logic              scan_done_q, scan_done_d;
    logic              overrun_q, overrun_d;
    logic [LINE_W-1:0] missed_q, missed_d;

    logic              line_due_s;
    logic [DIV_W:0]    acc_inc_s;
    logic [LINE_W-1:0] line_inc_s;

    assign acc_inc_s  = acc_q + {{DIV_W{1'b0}}, 1'b1};
    assign line_inc_s = line_cnt_q + {{(LINE_W-1){1'b0}}, 1'b1};

    // Next-state, position tracking and line scheduling.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        acc_d       = acc_q;
        div_d       = div_q;
        lines_d     = lines_q;
        line_cnt_d  = line_cnt_q;
        line_trig_d = 1'b0;
        line_num_d  = line_num_q;
        scan_done_d = 1'b0;
        overrun_d   = overrun_q;
        missed_d    = missed_q;
        line_due_s  = 1'b0;

        case ({bus.ENC_FWD, bus.ENC_REV})
            2'b10:   pos_d = pos_q + {{(POS_W-1){1'b0}}, 1'b1};
            2'b01:   pos_d = pos_q - {{(POS_W-1){1'b0}}, 1'b1};
            default: pos_d = pos_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    div_d      = (bus.CFG_DIV == {DIV_W{1'b0}}) ?
                                 {{(DIV_W-1){1'b0}}, 1'b1} : bus.CFG_DIV;
                    lines_d    = bus.CFG_LINES;
                    acc_d      = {(DIV_W+1){1'b0}};
                    line_cnt_d = {LINE_W{1'b0}};
                    overrun_d  = 1'b0;
                    missed_d   = {LINE_W{1'b0}};
                    if (bus.CFG_LINES == {LINE_W{1'b0}}) begin
                        scan_done_d = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    // Reverse steps push acc negative so backlash is re-traversed.
                    case ({bus.ENC_FWD, bus.ENC_REV})
                        2'b10: begin
                            if (acc_inc_s == {1'b0, div_q}) begin
                                acc_d      = {(DIV_W+1){1'b0}};
                                line_due_s = 1'b1;
                            end else begin
                                acc_d = acc_inc_s;
                            end
                        end
                        2'b01: begin
                            if (acc_q == ACC_MIN) begin
                                acc_d = acc_q;
                            end else begin
                                acc_d = acc_q - {{DIV_W{1'b0}}, 1'b1};
                            end
                        end
                        default: acc_d = acc_q;
                    endcase

                    if (line_due_s) begin
                        if (!bus.ACQ_BUSY) begin
                            line_trig_d = 1'b1;
                            line_num_d  = line_cnt_q;
                        end else begin
                            overrun_d = 1'b1;
                            if (missed_q != {LINE_W{1'b1}}) begin
                                missed_d = missed_q + {{(LINE_W-1){1'b0}}, 1'b1};
                            end else begin
                                missed_d = missed_q;
                            end
                        end
                        line_cnt_d = line_inc_s;
                        if (line_inc_s == lines_q) begin
                            scan_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        scan_active_d = (state_d == ST_SCAN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            pos_q         <= {POS_W{1'b0}};
            acc_q         <= {(DIV_W+1){1'b0}};
            div_q         <= {DIV_W{1'b0}};
            lines_q       <= {LINE_W{1'b0}};
            line_cnt_q    <= {LINE_W{1'b0}};
            line_trig_q   <= 1'b0;
            line_num_q    <= {LINE_W{1'b0}};
            scan_active_q <= 1'b0;
            scan_done_q   <= 1'b0;
            overrun_q     <= 1'b0;
            missed_q      <= {LINE_W{1'b0}};
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            acc_q         <= acc_d;
            div_q         <= div_d;
            lines_q       <= lines_d;
            line_cnt_q    <= line_cnt_d;
            line_trig_q   <= line_trig_d;
            line_num_q    <= line_num_d;
            scan_active_q <= scan_active_d;
            scan_done_q   <= scan_done_d;
            overrun_q     <= overrun_d;
            missed_q      <= missed_d;
        end
    end

    assign bus.LINE_TRIG   = line_trig_q;
    assign bus.LINE_NUM    = line_num_q;
    assign bus.POSITION    = pos_q;
    assign bus.SCAN_ACTIVE = scan_active_q;
    assign bus.SCAN_DONE   = scan_done_q;
    assign bus.OVERRUN     = overrun_q;
    assign bus.MISSED_CNT  = missed_q;

endmodule

// File: tb/tb_scan_line_trigger.sv
// Self-checking bench: directed scan scenarios plus random traffic, compared
// every cycle against a behavioural model of the scheduler.
module tb_scan_line_trigger;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    scan_line_trigger_if #(.POS_W(32), .DIV_W(16), .LINE_W(16)) bus ();

    scan_line_trigger #(.POS_W(32), .DIV_W(16), .LINE_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    logic [31:0] m_pos;
    bit          m_scan;
    int          m_acc, m_div, m_lines, m_line, m_missed;
    bit          m_trig, m_done, m_over;
    int          m_num;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit f, input bit r, input bit st, input bit ab,
                              input bit busy, input int cdiv, input int clines, input bit rst);
        int delta;
        bit due;
        delta  = (f && !r) ? 1 : ((r && !f) ? -1 : 0);
        m_trig = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_pos = 32'd0; m_scan = 1'b0; m_acc = 0; m_div = 0; m_lines = 0;
            m_line = 0; m_missed = 0; m_over = 1'b0; m_num = 0;
            return;
        end
        m_pos = m_pos + 32'(delta);
        if (!m_scan) begin
            if (st) begin
                m_div    = (cdiv == 0) ? 1 : cdiv;
                m_lines  = clines;
                m_acc    = 0;
                m_line   = 0;
                m_over   = 1'b0;
                m_missed = 0;
                if (m_lines == 0) m_done = 1'b1;
                else              m_scan = 1'b1;
            end
        end else if (ab) begin
            m_scan = 1'b0;
        end else begin
            due = 1'b0;
            if (delta == 1) begin
                if (m_acc + 1 == m_div) begin m_acc = 0; due = 1'b1; end
                else m_acc = m_acc + 1;
            end else if (delta == -1) begin
                m_acc = (m_acc - 1 < -65536) ? -65536 : m_acc - 1;
            end
            if (due) begin
                if (!busy) begin m_trig = 1'b1; m_num = m_line; end
                else begin
                    m_over = 1'b1;
                    if (m_missed < 65535) m_missed = m_missed + 1;
                end
                m_line = m_line + 1;
                if (m_line == m_lines) begin m_done = 1'b1; m_scan = 1'b0; end
            end
        end
    endtask

    int cfg_div   = 0;
    int cfg_lines = 0;

    task automatic step(input bit f, input bit r, input bit st, input bit ab, input bit busy);
        bus.ENC_FWD   = f;
        bus.ENC_REV   = r;
        bus.START     = st;
        bus.ABORT     = ab;
        bus.ACQ_BUSY  = busy;
        bus.CFG_DIV   = 16'(cfg_div);
        bus.CFG_LINES = 16'(cfg_lines);
        @(posedge CLK);
        #1;
        model_step(f, r, st, ab, busy, cfg_div, cfg_lines, RST);
        chk("line_trig",   {31'd0, bus.LINE_TRIG},   {31'd0, m_trig});
        chk("line_num",    {16'd0, bus.LINE_NUM},    32'(m_num));
        chk("position",    bus.POSITION,             m_pos);
        chk("scan_active", {31'd0, bus.SCAN_ACTIVE}, {31'd0, m_scan});
        chk("scan_done",   {31'd0, bus.SCAN_DONE},   {31'd0, m_done});
        chk("overrun",     {31'd0, bus.OVERRUN},     {31'd0, m_over});
        chk("missed_cnt",  {16'd0, bus.MISSED_CNT},  32'(m_missed));
    endtask

    task automatic fwd_n(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, busy);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_scan(input int d, input int l);
        cfg_div = d; cfg_lines = l;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        RST = 1'b1;
        idle_n(3);
        RST = 1'b0;

        // Position tracking in IDLE: 5 forward, 2 reverse
        fwd_n(5, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_position", bus.POSITION, 32'd3);
        idle_n(2);

        // Basic scan: div 4, 3 lines, 12 forward steps
        start_scan(4, 3);
        fwd_n(12, 1'b0);
        idle_n(3);

        // Backlash: 3 fwd, 2 rev, simultaneous strobes, then forward
        start_scan(4, 2);
        fwd_n(3, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        fwd_n(10, 1'b0);
        idle_n(2);

        // Busy while line 1 is due
        start_scan(2, 3);
        fwd_n(3, 1'b0);
        fwd_n(1, 1'b1);
        fwd_n(2, 1'b0);
        idle_n(2);

        // Abort on the 16th forward step, with one dropped line beforehand
        start_scan(4, 10);
        fwd_n(7, 1'b0);
        fwd_n(1, 1'b1);
        fwd_n(7, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(2);
        start_scan(1, 1);
        fwd_n(1, 1'b0);
        idle_n(2);

        // Edge configs: zero lines, zero divider, START during SCAN
        start_scan(3, 0);
        idle_n(2);
        start_scan(0, 3);
        fwd_n(1, 1'b0);
        start_scan(5, 9);
        fwd_n(3, 1'b0);
        idle_n(2);

        // Reset mid-scan
        start_scan(2, 4);
        fwd_n(3, 1'b0);
        RST = 1'b1;
        idle_n(1);
        RST = 1'b0;
        idle_n(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit f, rv, st, ab, busy;
            r = $urandom_range(0, 9);
            f  = (r <= 5) || (r == 8);
            rv = (r == 6) || (r == 7) || (r == 8);
            st = ($urandom_range(0, 19) == 0);
            ab = ($urandom_range(0, 59) == 0);
            busy = ($urandom_range(0, 2) == 0);
            cfg_div   = $urandom_range(0, 5);
            cfg_lines = $urandom_range(0, 6);
            RST = ($urandom_range(0, 499) == 0);
            step(f, rv, st, ab, busy);
        end
        RST = 1'b0;
        idle_n(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
